// File: rtl/booth_mult_unit.sv
// Radix-2 Booth signed multiplier datapath driven by one-hot phase strobes fi0..fi5.
// Operands come in on INBUS; the 2N-bit product leaves on OUTBUS as high word, then low word.
module booth_mult_unit #(
    parameter int N = 8,
    localparam int CNT_W = $clog2(N) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fi0,
    input  logic             fi1,
    input  logic             fi2,
    input  logic             fi3,
    input  logic             fi4,
    input  logic             fi5,
    input  logic [N-1:0]     INBUS,
    output logic [N-1:0]     OUTBUS,
    output logic             OUT_VLD,
    output logic             END,
    output logic             ERR,
    output logic [CNT_W-1:0] dbg_cnt
);

    // OUT_VLD is a valid-only strobe: there is no ready.
    // The consumer must take OUTBUS in the cycle that OUT_VLD is high.
    logic [N-1:0]     m;
    logic [N:0]       a;
    logic [N-1:0]     q;
    logic             q_1;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       phase;
    logic             illegal;
    logic [N:0]       m_ext;

    assign phase   = {fi5, fi4, fi3, fi2, fi1, fi0};
    assign illegal = ($countones(phase) > 1);
    assign m_ext   = {m[N-1], m};
    assign dbg_cnt = cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            m       <= '0;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            OUTBUS  <= '0;
            OUT_VLD <= 1'b0;
            END     <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            OUT_VLD <= 1'b0;
            ERR     <= 1'b0;
            if (illegal) begin
                ERR <= 1'b1;
            end else begin
                if (fi0) begin
                    m <= INBUS;
                end
                if (fi1) begin
                    q   <= INBUS;
                    a   <= '0;
                    q_1 <= 1'b0;
                    cnt <= '0;
                    END <= 1'b0;
                end
                if (fi2 && !END) begin
                    case ({q[0], q_1})
                        2'b01:   a <= a + m_ext;
                        2'b10:   a <= a - m_ext;
                        default: a <= a;
                    endcase
                end
                // Concatenation assignment performs the arithmetic right shift of {A,Q,Q_1}.
                if (fi3 && !END) begin
                    {a, q, q_1} <= {a[N], a, q};
                    cnt         <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        END <= 1'b1;
                    end
                end
                if (fi4) begin
                    OUTBUS  <= a[N-1:0];
                    OUT_VLD <= 1'b1;
                end
                if (fi5) begin
                    OUTBUS  <= q;
                    OUT_VLD <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit (N=8): reset, signed products, mid-run reset,
// illegal phase combination and post-END behaviour, checked with immediate assertions.
module tb_booth_mult_unit;

    localparam int N = 8;

    logic         CLK;
    logic         RST;
    logic [5:0]   fi;
    logic [N-1:0] INBUS;
    logic [N-1:0] OUTBUS;
    logic         OUT_VLD;
    logic         END;
    logic         ERR;
    logic [3:0]   dbg_cnt;

    int n_checks;
    int n_fail;

    localparam logic [5:0] F0 = 6'b000001;
    localparam logic [5:0] F1 = 6'b000010;
    localparam logic [5:0] F2 = 6'b000100;
    localparam logic [5:0] F3 = 6'b001000;
    localparam logic [5:0] F4 = 6'b010000;
    localparam logic [5:0] F5 = 6'b100000;

    booth_mult_unit #(.N(N)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .fi0     (fi[0]),
        .fi1     (fi[1]),
        .fi2     (fi[2]),
        .fi3     (fi[3]),
        .fi4     (fi[4]),
        .fi5     (fi[5]),
        .INBUS   (INBUS),
        .OUTBUS  (OUTBUS),
        .OUT_VLD (OUT_VLD),
        .END     (END),
        .ERR     (ERR),
        .dbg_cnt (dbg_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic [5:0] f, input logic [N-1:0] d);
        fi    = f;
        INBUS = d;
        @(posedge CLK);
        #1;
        fi    = '0;
    endtask

    task automatic pairs(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(F2, 8'h00);
            cyc(F3, 8'h00);
        end
    endtask

    task automatic load(input logic [N-1:0] mv, input logic [N-1:0] qv);
        cyc(F0, mv);
        cyc(F1, qv);
        chk("end_clear_on_fi1", 16'(END), 16'h0);
        chk("cnt_clear_on_fi1", 16'(dbg_cnt), 16'h0);
    endtask

    task automatic iterate_full(input string tag);
        for (int i = 0; i < N; i++) begin
            cyc(F2, 8'h00);
            cyc(F3, 8'h00);
            chk({tag, "_end"}, 16'(END), (i == N - 1) ? 16'h1 : 16'h0);
        end
    endtask

    task automatic read_prod(input string tag, input logic [15:0] exp);
        cyc(F4, 8'h00);
        chk({tag, "_hi"}, 16'(OUTBUS), 16'(exp[15:8]));
        chk({tag, "_hi_vld"}, 16'(OUT_VLD), 16'h1);
        cyc(F5, 8'h00);
        chk({tag, "_lo"}, 16'(OUTBUS), 16'(exp[7:0]));
        chk({tag, "_lo_vld"}, 16'(OUT_VLD), 16'h1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fi       = '0;
        INBUS    = '0;
        RST      = 1'b1;

        // 1: reset with random phase/bus activity
        fi    = 6'($urandom_range(0, 63));
        INBUS = 8'($urandom_range(0, 255));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        fi  = '0;
        chk("rst_outbus", 16'(OUTBUS), 16'h0);
        chk("rst_vld", 16'(OUT_VLD), 16'h0);
        chk("rst_end", 16'(END), 16'h0);
        chk("rst_err", 16'(ERR), 16'h0);
        chk("rst_cnt", 16'(dbg_cnt), 16'h0);

        // 2: 7 x 3 = 21
        load(8'h07, 8'h03);
        iterate_full("m7x3");
        read_prod("m7x3", 16'h0015);
        cyc(6'b000000, 8'hAA);
        chk("idle_hold_bus", 16'(OUTBUS), 16'h0015 & 16'h00FF);
        chk("idle_vld", 16'(OUT_VLD), 16'h0);

        // 3: -5 x 3 = -15, -128 x -128 = 16384
        load(8'hFB, 8'h03);
        iterate_full("mn5x3");
        read_prod("mn5x3", 16'hFFF1);
        load(8'h80, 8'h80);
        iterate_full("mn128sq");
        read_prod("mn128sq", 16'h4000);

        // 4: reset in the middle of a run, then a fresh run
        load(8'h07, 8'h03);
        pairs(3);
        chk("mid_cnt_before_rst", 16'(dbg_cnt), 16'h3);
        cyc(F5, 8'h00);
        chk("mid_vld_before_rst", 16'(OUT_VLD), 16'h1);
        RST = 1'b1;
        cyc(F2, 8'h55);
        RST = 1'b0;
        chk("midrst_outbus", 16'(OUTBUS), 16'h0);
        chk("midrst_vld", 16'(OUT_VLD), 16'h0);
        chk("midrst_end", 16'(END), 16'h0);
        chk("midrst_err", 16'(ERR), 16'h0);
        chk("midrst_cnt", 16'(dbg_cnt), 16'h0);
        load(8'h07, 8'h03);
        iterate_full("after_rst");
        read_prod("after_rst", 16'h0015);

        // 5: illegal fi2+fi3 in the middle of a run
        load(8'h07, 8'h03);
        pairs(4);
        cyc(F2 | F3, 8'h00);
        chk("illegal_err", 16'(ERR), 16'h1);
        chk("illegal_vld", 16'(OUT_VLD), 16'h0);
        chk("illegal_cnt", 16'(dbg_cnt), 16'h4);
        cyc(F4 | F5, 8'h00);
        chk("illegal2_err", 16'(ERR), 16'h1);
        chk("illegal2_vld", 16'(OUT_VLD), 16'h0);
        cyc(6'b000000, 8'h00);
        chk("illegal_err_one_cycle", 16'(ERR), 16'h0);
        pairs(3);
        chk("illegal_end_not_yet", 16'(END), 16'h0);
        pairs(1);
        chk("illegal_end_done", 16'(END), 16'h1);
        read_prod("illegal_run", 16'h0015);

        // 6: extra iterations after END change nothing
        pairs(2);
        chk("post_end_end", 16'(END), 16'h1);
        chk("post_end_cnt", 16'(dbg_cnt), 16'h8);
        read_prod("post_end", 16'h0015);
        cyc(F1, 8'h01);
        chk("fi1_clears_end", 16'(END), 16'h0);
        chk("fi1_clears_cnt", 16'(dbg_cnt), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
